if_fetch: RTL and testbench

Instruction-fetch stage: the producer side of the IF/ID pipeline register. It owns the PC, assembles each 32-bit instruction from the byte-wide memory port via a small fetch FSM, and presents `if_pc`/`if_inst` to IF/ID. It raises a stall request while no instruction is ready, follows the shared `stall` vector, and redirects on `branch_flag_i`.

---
 rtl/if_fetch_pkg.sv | 33 +++
 rtl/if_icache.sv | 57 +++++
 rtl/if_fetch.sv | 146 ++++++++++++++
 tb/tb_if_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and byte-lane helper for the instruction fetch stage.
// The ICACHE_EN macro stays undefined by default, which builds the stage without a cache.
package if_fetch_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        STOP        = 1'b1;
    localparam logic        NO_STOP     = 1'b0;
    localparam logic        BRANCH      = 1'b1;
    localparam logic [2:0]  LANES       = 3'd4;

    typedef enum logic {
        FETCH = 1'b0,
        READY = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill.
// Only instantiated when ICACHE_EN is defined.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_data
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [TAG_W-1:0]   tag_r  [ENTRIES];
    logic [INST_W-1:0]  data_r [ENTRIES];
    logic [ENTRIES-1:0] valid_r;
    logic [IDX_W-1:0]   rd_idx_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               unused_lsb_s;

    assign rd_idx_s     = lookup_pc[IDX_W+1:2];
    assign wr_idx_s     = wr_pc[IDX_W+1:2];
    assign unused_lsb_s = ^{lookup_pc[1:0], wr_pc[1:0]};

    // Tag compare against the addressed entry
    always_comb begin
        hit      = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == lookup_pc[INST_ADDR_W-1:IDX_W+2]);
        hit_data = data_r[rd_idx_s];
    end

    // Valid bits are the only cache state that must come up cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage written on fill
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx_s]  <= wr_pc[INST_ADDR_W-1:IDX_W+2];
            data_r[wr_idx_s] <= wr_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC and assembles 32-bit instructions from a byte-wide port.
// Define ICACHE_EN to add the direct-mapped if_icache in front of the byte fetch.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        mem_busy_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_o
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  buf_r, buf_s;
    logic [2:0]   cnt_r, cnt_s;
    logic         pend_vld_r, pend_vld_s;
    logic [1:0]   pend_lane_r, pend_lane_s;
    logic         issue_s;
    logic         capture_s;
    logic         done_s;
    logic         hit_s;
    logic [31:0]  hit_data_s;

`ifdef ICACHE_EN
    logic        cache_hit_s;
    logic [31:0] fill_data_s;
    logic        unused_stall_s;

    assign fill_data_s    = put_byte(buf_r, 2'd3, mem_rdata_i);
    assign unused_stall_s = ^stall[5:1];

    if_icache #(
        .ENTRIES (ICACHE_ENTRIES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (pc_r),
        .hit       (cache_hit_s),
        .hit_data  (hit_data_s),
        .wr_en     (done_s),
        .wr_pc     (pc_r),
        .wr_data   (fill_data_s)
    );

    // A lookup only counts before any byte of this instruction has been requested
    assign hit_s = cache_hit_s && (state_r == FETCH) && (cnt_r == 3'd0) && !pend_vld_r;
`else
    logic unused_s;

    assign hit_s      = 1'b0;
    assign hit_data_s = ZERO_WORD;
    assign unused_s   = ^{stall[5:1], ICACHE_ENTRIES[0]};
`endif

    assign issue_s   = (state_r == FETCH) && (cnt_r < LANES) && !mem_busy_i
                       && (branch_flag_i != BRANCH) && !hit_s;
    assign capture_s = pend_vld_r && (branch_flag_i != BRANCH);
    assign done_s    = capture_s && (pend_lane_r == 2'd3);

    // Next-state: redirect beats stall and any fetch progress
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        cnt_s       = cnt_r;
        buf_s       = buf_r;
        pend_vld_s  = 1'b0;
        pend_lane_s = pend_lane_r;
        if (branch_flag_i == BRANCH) begin
            pc_s    = branch_target_i;
            cnt_s   = 3'd0;
            state_s = FETCH;
        end else begin
            if (capture_s) begin
                buf_s = put_byte(buf_r, pend_lane_r, mem_rdata_i);
            end else begin
                buf_s = buf_r;
            end
            if (issue_s) begin
                cnt_s       = cnt_r + 3'd1;
                pend_vld_s  = 1'b1;
                pend_lane_s = cnt_r[1:0];
            end else begin
                cnt_s = cnt_r;
            end
            case (state_r)
                FETCH: begin
                    if (hit_s) begin
                        buf_s   = hit_data_s;
                        state_s = READY;
                    end else if (done_s) begin
                        state_s = READY;
                    end else begin
                        state_s = FETCH;
                    end
                end
                READY: begin
                    if (stall[0] == NO_STOP) begin
                        pc_s    = pc_r + 32'd4;
                        cnt_s   = 3'd0;
                        state_s = FETCH;
                    end else begin
                        state_s = READY;
                    end
                end
                default: state_s = FETCH;
            endcase
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= FETCH;
            pc_r        <= ZERO_WORD;
            cnt_r       <= 3'd0;
            buf_r       <= ZERO_WORD;
            pend_vld_r  <= 1'b0;
            pend_lane_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            cnt_r       <= cnt_s;
            buf_r       <= buf_s;
            pend_vld_r  <= pend_vld_s;
            pend_lane_r <= pend_lane_s;
        end
    end

    // Gating with rst keeps the port silent the moment reset is asserted
    assign mem_req_o  = issue_s && rst;
    assign mem_addr_o = mem_req_o ? (pc_r + {29'd0, cnt_r}) : ZERO_WORD;
    assign if_pc      = pc_r;
    assign if_inst    = buf_r;
    assign stallreq_o = (state_r != READY);

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a cycle-count reference model predicts request addresses,
// completion latency and presented instructions; a monitor process pops and compares.
module tb_if_fetch;

    localparam int ENTRIES = 64;
    localparam int IW      = $clog2(ENTRIES);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        mem_busy_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_rdata_i = 8'd0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_err = 0;
    int scenario = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        held;
    logic [31:0] m_pc;
    int          m_issued;
    int          m_ready;
    int          rcyc;
    logic [31:0] c_pc [ENTRIES];
    logic        c_v  [ENTRIES];
    logic        r_req;
    logic [31:0] r_addr;

    always #5 clk = ~clk;

    if_fetch #(.ICACHE_ENTRIES(ENTRIES)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_busy_i      (mem_busy_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_rdata_i     (mem_rdata_i),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_o      (stallreq_o)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 8'h13;
        if (a < 32'd4) return 8'h00;
        h = a * 32'h9E37_79B1;
        return h[23:16] ^ a[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @rcyc %0d: got 0x%08h, expected 0x%08h", name, rcyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Byte memory: answers each request with its byte in the following cycle, garbage otherwise
    initial begin
        forever begin
            @(negedge clk);
            r_req  = mem_req_o;
            r_addr = mem_addr_o;
            @(posedge clk);
            #1;
            mem_rdata_i = r_req ? mem_byte(r_addr) : 8'($urandom);
        end
    end

    // Reference model and scoreboard monitor
    initial begin
        exp_t e;
        logic presenting;
        logic exp_req;
        logic hit;
        int   idx;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_stallreq", 32'(stallreq_o), 32'd1);
                chk("rst_req", 32'(mem_req_o), 32'd0);
                chk("rst_addr", mem_addr_o, 32'd0);
                chk("rst_pc", if_pc, 32'd0);
                chk("rst_inst", if_inst, 32'd0);
                m_pc     = 32'd0;
                m_issued = 0;
                m_ready  = -1;
                rcyc     = 0;
                sb_q.delete();
                sb_q.push_back('{32'd0, mem_word(32'd0)});
                for (int i = 0; i < ENTRIES; i++) c_v[i] = 1'b0;
            end else begin
                presenting = (m_ready >= 0) && (rcyc >= m_ready);
                idx = int'(m_pc[IW+1:2]);
                hit = 1'b0;
`ifdef ICACHE_EN
                hit = !presenting && (m_issued == 0) && !branch_flag_i && c_v[idx] && (c_pc[idx] == m_pc);
`endif
                exp_req = !presenting && (m_issued < 4) && !mem_busy_i && !branch_flag_i && !hit;
                chk("stallreq", 32'(stallreq_o), 32'(!presenting));
                chk("mem_req", 32'(mem_req_o), 32'(exp_req));
                chk("mem_addr", mem_addr_o, exp_req ? (m_pc + 32'(m_issued)) : 32'd0);
                if (presenting && (rcyc == m_ready)) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_empty @rcyc %0d: got if_pc 0x%08h, expected a queued entry", rcyc, if_pc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("if_pc", if_pc, e.pc);
                        chk("if_inst", if_inst, e.inst);
                        held = e;
                    end
                    c_v[idx]  = 1'b1;
                    c_pc[idx] = m_pc;
                end else if (presenting) begin
                    chk("hold_pc", if_pc, held.pc);
                    chk("hold_inst", if_inst, held.inst);
                end
                case (scenario)
                    1: begin
                        if (rcyc < 4) begin
                            chk("t1_req", 32'(mem_req_o), 32'd1);
                            chk("t1_addr", mem_addr_o, 32'(rcyc));
                        end
                        if (rcyc == 4) chk("t1_stallreq4", 32'(stallreq_o), 32'd1);
                        if (rcyc == 5) begin
                            chk("t1_stallreq5", 32'(stallreq_o), 32'd0);
                            chk("t1_inst", if_inst, 32'h0000_0013);
                        end
                    end
                    2: begin
                        if (rcyc == 0) chk("t2_addr0", mem_addr_o, 32'd0);
                        if (rcyc == 1) chk("t2_req1", 32'(mem_req_o), 32'd0);
                        if (rcyc >= 2 && rcyc <= 4) chk("t2_addr", mem_addr_o, 32'(rcyc - 1));
                        if (rcyc == 5) chk("t2_stallreq5", 32'(stallreq_o), 32'd1);
                        if (rcyc == 6) chk("t2_stallreq6", 32'(stallreq_o), 32'd0);
                    end
                    3: begin
                        if (rcyc == 2) chk("t3_req_br", 32'(mem_req_o), 32'd0);
                        if (rcyc == 3) chk("t3_addr", mem_addr_o, 32'h0000_0100);
                        if (rcyc == 8) chk("t3_pc", if_pc, 32'h0000_0100);
                    end
                    7: begin
                        if (rcyc >= 19 && rcyc <= 24) chk("t7_noreq", 32'(mem_req_o), 32'd0);
                        if (rcyc == 20 || rcyc == 22 || rcyc == 24) begin
                            chk("t7_ready", 32'(stallreq_o), 32'd0);
                            chk("t7_pc", if_pc, 32'(2 * (rcyc - 20)));
                        end
                    end
                    default: ;
                endcase
                if (branch_flag_i) begin
                    m_pc     = branch_target_i;
                    m_issued = 0;
                    m_ready  = -1;
                    sb_q.delete();
                    sb_q.push_back('{m_pc, mem_word(m_pc)});
                end else if (presenting && !stall[0]) begin
                    m_pc     = m_pc + 32'd4;
                    m_issued = 0;
                    m_ready  = -1;
                    sb_q.push_back('{m_pc, mem_word(m_pc)});
                end else if (hit) begin
                    m_ready = rcyc + 1;
                end else if (exp_req) begin
                    m_issued++;
                    if (m_issued == 4) m_ready = rcyc + 2;
                end
                rcyc++;
            end
        end
    end

    // Stimulus
    initial begin
        #1;
        rst = 1'b0;
        repeat (3) next_cycle();

        // cold fetch of 0x00000013 at address 0
        scenario = 1;
        rst = 1'b1;
        repeat (10) next_cycle();

        // reset mid-fetch, then one busy cycle
        scenario = 0;
        rst = 1'b0;
        repeat (2) next_cycle();
        scenario = 2;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mem_busy_i = (c == 1);
            next_cycle();
        end
        mem_busy_i = 1'b0;

        // redirect to 0x100 while lane 1 is in flight
        scenario = 0;
        rst = 1'b0;
        repeat (2) next_cycle();
        scenario = 3;
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            branch_flag_i   = (c == 2);
            branch_target_i = 32'h0000_0100;
            next_cycle();
        end
        branch_flag_i = 1'b0;
        scenario = 0;

        // hold in READY under stall, then release
        stall = 6'b000001;
        repeat (10) next_cycle();
        stall = 6'b000000;
        repeat (8) next_cycle();

        // PC wrap from 0xFFFFFFFC
        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        next_cycle();
        branch_flag_i = 1'b0;
        repeat (14) next_cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst             = (($urandom % 1000) < 3) ? 1'b0 : 1'b1;
            mem_busy_i      = (($urandom % 100) < 30);
            branch_flag_i   = (($urandom % 100) < 3);
            branch_target_i = (($urandom % 8) == 0) ? {28'hFFF_FFFF, 2'($urandom), 2'b00}
                                                    : {24'd0, 6'($urandom), 2'b00};
            stall           = {5'($urandom), (($urandom % 100) < 40)};
            next_cycle();
        end
        rst = 1'b1;
        mem_busy_i = 1'b0;
        branch_flag_i = 1'b0;
        stall = 6'd0;
        repeat (4) next_cycle();

`ifdef ICACHE_EN
        // loop 0x0-0x8 twice: the second pass must hit every time
        rst = 1'b0;
        repeat (2) next_cycle();
        scenario = 7;
        rst = 1'b1;
        for (int c = 0; c < 28; c++) begin
            branch_flag_i   = (c == 18);
            branch_target_i = 32'd0;
            next_cycle();
        end
        branch_flag_i = 1'b0;
        scenario = 0;
`endif

        repeat (2) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
